everloop_rx: RTL and testbench

Single-wire NRZ pulse-width decoder for the Everloop LED chain protocol, the receive-side counterpart of the Everloop LED driver. It samples the serial line, classifies each high pulse as a 1 or 0 bit, and assembles bits MSB-first into bytes. Each completed byte is written to a byte-wide memory port with an incrementing address. A long low gap is detected as a frame reset and reported. The block sits in bench and loopback paths, and on any board input that must capture an LED stream.

---
 rtl/everloop_pkg.sv | 31 +++
 rtl/everloop_sync.sv | 41 ++++
 rtl/everloop_rx.sv | 182 ++++++++++++++++++
 tb/tb_everloop_rx.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/everloop_pkg.sv
// everloop_pkg
// Shared definitions for the Everloop LED chain driver and receiver.
//   - Decoder state encoding (HUNT, IDLE, HIGH, LOW) as plain localparams
//     so that older tools can also consume this package.
//   - Driver bit timings and frame geometry at 150 MHz. Both sides of the
//     link use these values.
//   - Default decoder thresholds used by everloop_rx.
package everloop_pkg;

    // Decoder state encoding
    localparam logic [1:0] ST_HUNT = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_LOW  = 2'd3;

    // Driver timings in clk cycles: a 1 is 120 high / 120 low, a 0 is 60 high / 180 low
    localparam int T1H_CYCLES    = 120;
    localparam int T1L_CYCLES    = 120;
    localparam int T0H_CYCLES    = 60;
    localparam int T0L_CYCLES    = 180;
    localparam int RESET_CYCLES  = 16300;
    localparam int FRAME_BYTES_DEFAULT = 141;

    // Receiver defaults. The reset threshold is well below the driver's gap,
    // so a gap is recognised with margin.
    localparam int HI_THRESH_DEFAULT  = 90;
    localparam int MIN_HI_DEFAULT     = 16;
    localparam int MAX_HI_DEFAULT     = 250;
    localparam int RST_CYCLES_DEFAULT = 8000;

endpackage

// File: rtl/everloop_sync.sv
// everloop_sync
// Brings the asynchronous serial line into the clk domain and detects its edges.
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous, active-low reset
//   d      in   raw serial line
//   level  out  synchronized line level
//   rise   out  one-cycle pulse on a synchronized 0->1 transition
//   fall   out  one-cycle pulse on a synchronized 1->0 transition
module everloop_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Two flops for metastability. The third flop only delays the clean
    // value by one cycle so that edges can be compared against it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~prev_q;
    assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/everloop_rx.sv
// everloop_rx
// Pulse-width decoder for the Everloop LED chain.
//   - Each high pulse is classified as a 1 (long) or a 0 (short).
//   - Bits are packed MSB-first into bytes.
//   - Each completed byte is written to a byte-wide memory port.
//   - A long low gap closes the frame.
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous, active-low reset
//   everloop_d  in   serial line (asynchronous to clk)
//   address     out  write address of the byte on data_RGB
//   data_RGB    out  decoded byte
//   wr_en       out  one-cycle write strobe
//   frame_done  out  one-cycle pulse at frame end
//   frame_len   out  bytes written in the last frame
//   err         out  sticky error, cleared on the first bit of the next frame
module everloop_rx
    import everloop_pkg::*;
#(
    parameter int HI_THRESH   = HI_THRESH_DEFAULT,
    parameter int MIN_HI      = MIN_HI_DEFAULT,
    parameter int MAX_HI      = MAX_HI_DEFAULT,
    parameter int RST_CYCLES  = RST_CYCLES_DEFAULT,
    parameter int FRAME_BYTES = FRAME_BYTES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       everloop_d,
    output logic [7:0] address,
    output logic [7:0] data_RGB,
    output logic       wr_en,
    output logic       frame_done,
    output logic [7:0] frame_len,
    output logic       err
);

    localparam logic [7:0]  HI_THRESH_C   = 8'(HI_THRESH);
    localparam logic [7:0]  MIN_HI_C      = 8'(MIN_HI);
    localparam logic [7:0]  MAX_HI_C      = 8'(MAX_HI);
    localparam logic [14:0] RST_CYCLES_C  = 15'(RST_CYCLES);
    localparam logic [7:0]  FRAME_BYTES_C = 8'(FRAME_BYTES);

    logic        line_level;
    logic        line_rise;
    logic        line_fall;

    logic [1:0]  state;
    logic [7:0]  hi_cnt;
    logic [14:0] lo_cnt;
    logic [2:0]  bit_cnt;
    logic [6:0]  shift_q;

    logic [7:0]  hi_inc;
    logic [14:0] lo_inc;
    logic        lo_term;
    logic        bit_val;

    everloop_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .d     (everloop_d),
        .level (line_level),
        .rise  (line_rise),
        .fall  (line_fall)
    );

    // Saturating increments. lo_term fires in the cycle in which lo_cnt reaches
    // the reset length, so frame_done lines up with that count.
    assign hi_inc  = (hi_cnt == 8'hFF) ? hi_cnt : hi_cnt + 8'd1;
    assign lo_inc  = (lo_cnt == 15'h7FFF) ? lo_cnt : lo_cnt + 15'd1;
    assign lo_term = (lo_inc == RST_CYCLES_C);
    assign bit_val = (hi_cnt >= HI_THRESH_C);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_HUNT;
            hi_cnt     <= 8'd0;
            lo_cnt     <= 15'd0;
            bit_cnt    <= 3'd0;
            shift_q    <= 7'd0;
            address    <= 8'd0;
            data_RGB   <= 8'd0;
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            frame_len  <= 8'd0;
            err        <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;

            // The address advances in the cycle after the strobe, so the
            // written byte is presented with the address it belongs to.
            if (wr_en) begin
                address <= address + 8'd1;
            end

            case (state)
                ST_HUNT: begin
                    // After reset or a stuck line, wait for one full gap so
                    // that decoding never starts in the middle of a frame.
                    if (line_level) begin
                        lo_cnt <= 15'd0;
                    end else begin
                        lo_cnt <= lo_inc;
                        if (lo_term) begin
                            address <= 8'd0;
                            bit_cnt <= 3'd0;
                            state   <= ST_IDLE;
                        end
                    end
                end

                ST_IDLE: begin
                    // The rise cycle is already high, so the count starts at 1.
                    // At the fall, hi_cnt then equals the synchronized high width.
                    if (line_rise) begin
                        hi_cnt <= 8'd1;
                        err    <= 1'b0;
                        state  <= ST_HIGH;
                    end
                end

                ST_HIGH: begin
                    if (hi_cnt >= MAX_HI_C) begin
                        // Stuck line: drop the partial byte and the frame's
                        // addressing, then resynchronise on a gap.
                        err     <= 1'b1;
                        bit_cnt <= 3'd0;
                        address <= 8'd0;
                        lo_cnt  <= 15'd0;
                        state   <= ST_HUNT;
                    end else if (line_fall) begin
                        // A glitch also restarts the gap count, so a stale
                        // count can never step past the terminal value.
                        lo_cnt <= 15'd0;
                        state  <= ST_LOW;
                        if (hi_cnt >= MIN_HI_C) begin
                            shift_q <= {shift_q[5:0], bit_val};
                            if (bit_cnt == 3'd7) begin
                                bit_cnt <= 3'd0;
                                if (address >= FRAME_BYTES_C) begin
                                    err <= 1'b1;
                                end else begin
                                    wr_en    <= 1'b1;
                                    data_RGB <= {shift_q, bit_val};
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end else begin
                        hi_cnt <= hi_inc;
                    end
                end

                ST_LOW: begin
                    // When the terminal count and a rise arrive together, the
                    // frame end takes priority and the rise is dropped.
                    lo_cnt <= lo_inc;
                    if (lo_term) begin
                        frame_done <= 1'b1;
                        frame_len  <= address;
                        if (bit_cnt != 3'd0) begin
                            err <= 1'b1;
                        end
                        address <= 8'd0;
                        bit_cnt <= 3'd0;
                        state   <= ST_IDLE;
                    end else if (line_rise) begin
                        hi_cnt <= 8'd1;
                        state  <= ST_HIGH;
                    end
                end

                default: begin
                    state <= ST_HUNT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_everloop_rx.sv
// tb_everloop_rx
// Bench for everloop_rx, run with scaled-down timing parameters so that
// full 141-byte frames stay short. Frames are built from byte lists. The
// expected writes, frame length and error flag come from frame-level rules
// applied to those lists.
module tb_everloop_rx;

    localparam int HI_THRESH   = 10;
    localparam int MIN_HI      = 4;
    localparam int MAX_HI      = 30;
    localparam int RST_CYCLES  = 200;
    localparam int FRAME_BYTES = 141;
    localparam int GAP         = 300;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       everloop_d = 1'b0;
    logic [7:0] address;
    logic [7:0] data_RGB;
    logic       wr_en;
    logic       frame_done;
    logic [7:0] frame_len;
    logic       err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_fall_cyc = 0;

    logic [7:0] tx_bytes[$];
    logic [7:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    int         wr_cyc_q[$];
    int         fd_count = 0;
    int         fd_len = 0;
    int         fd_err = 0;
    int         fd_cyc = 0;

    everloop_rx #(
        .HI_THRESH   (HI_THRESH),
        .MIN_HI      (MIN_HI),
        .MAX_HI      (MAX_HI),
        .RST_CYCLES  (RST_CYCLES),
        .FRAME_BYTES (FRAME_BYTES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .everloop_d (everloop_d),
        .address    (address),
        .data_RGB   (data_RGB),
        .wr_en      (wr_en),
        .frame_done (frame_done),
        .frame_len  (frame_len),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Outputs are sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (wr_en) begin
            wr_addr_q.push_back(address);
            wr_data_q.push_back(data_RGB);
            wr_cyc_q.push_back(cyc);
        end
        if (frame_done) begin
            fd_count = fd_count + 1;
            fd_len   = int'(frame_len);
            fd_err   = int'(err);
            fd_cyc   = cyc;
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks = checks + 1;
        if (observed !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clear_monitor();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        fd_count = 0;
    endtask

    // One high pulse followed by a low run. The first edge that samples
    // the fall is recorded for the latency checks.
    task automatic send_pulse(input int hi, input int lo);
        everloop_d = 1'b1;
        repeat (hi) @(negedge clk);
        everloop_d = 1'b0;
        last_fall_cyc = cyc + 1;
        repeat (lo) @(negedge clk);
    endtask

    // Widths vary across the whole legal range on either side of the
    // decision threshold and above the glitch limit.
    task automatic send_bit(input bit b, input bit glitch);
        int hi;
        int lo;
        hi = b ? $urandom_range(MAX_HI - 1, HI_THRESH) : $urandom_range(HI_THRESH - 1, MIN_HI);
        lo = $urandom_range(24, 6);
        if (glitch) begin
            send_pulse(hi, 3);
            send_pulse($urandom_range(MIN_HI - 1, 1), lo);
        end else begin
            send_pulse(hi, lo);
        end
    endtask

    // glitch_mode: 0 none, 1 random (never on the final bit), 2 forced after bit 4
    task automatic send_byte(input logic [7:0] v, input int glitch_mode);
        logic [7:0] b;
        bit g;
        b = v;
        for (int i = 7; i >= 0; i--) begin
            g = (i != 0) && ((glitch_mode == 1 && $urandom_range(3, 0) == 0) || (glitch_mode == 2 && i == 4));
            send_bit(b[i], g);
        end
    endtask

    task automatic applyStimulus(input int extra_bits, input int glitch_mode);
        for (int i = 0; i < tx_bytes.size(); i++) begin
            send_byte(tx_bytes[i], glitch_mode);
        end
        for (int i = 0; i < extra_bits; i++) begin
            send_bit(1'($urandom_range(1, 0)), 1'b0);
        end
        repeat (GAP) @(negedge clk);
    endtask

    // Frame-level expectations:
    //   - the first FRAME_BYTES bytes are written at addresses 0.. in order;
    //   - err is set by overflow or by leftover bits at the gap;
    //   - frame_done comes RST_CYCLES+2 cycles after the last fall;
    //   - the last write comes 2 cycles after the fall of the last bit.
    task automatic run_frame(input string name, input int extra_bits, input int glitch_mode);
        int n;
        int nw;
        int exp_err;
        clear_monitor();
        applyStimulus(extra_bits, glitch_mode);
        n       = tx_bytes.size();
        nw      = (n > FRAME_BYTES) ? FRAME_BYTES : n;
        exp_err = ((n > FRAME_BYTES) || (extra_bits != 0)) ? 1 : 0;
        checkOutput({name, " wr_count"}, wr_addr_q.size(), nw);
        for (int i = 0; i < wr_addr_q.size() && i < nw; i++) begin
            checkOutput($sformatf("%s addr[%0d]", name, i), wr_addr_q[i], i);
            checkOutput($sformatf("%s data[%0d]", name, i), wr_data_q[i], tx_bytes[i]);
        end
        checkOutput({name, " frame_done_count"}, fd_count, 1);
        checkOutput({name, " frame_len"}, fd_len, nw);
        checkOutput({name, " err"}, fd_err, exp_err);
        checkOutput({name, " frame_done_latency"}, fd_cyc - last_fall_cyc, RST_CYCLES + 2);
        if (extra_bits == 0 && n > 0 && n <= FRAME_BYTES && wr_cyc_q.size() > 0) begin
            checkOutput({name, " wr_latency"}, wr_cyc_q[wr_cyc_q.size() - 1] - last_fall_cyc, 2);
        end
    endtask

    initial begin
        int n;
        int extra;

        // Reset state
        #2 rst = 1'b0;
        #2;
        checkOutput("reset address", address, 0);
        checkOutput("reset data_RGB", data_RGB, 0);
        checkOutput("reset wr_en", wr_en, 0);
        checkOutput("reset frame_done", frame_done, 0);
        checkOutput("reset frame_len", frame_len, 0);
        checkOutput("reset err", err, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (GAP) @(negedge clk);

        // Single byte
        tx_bytes.delete();
        tx_bytes.push_back(8'hA5);
        run_frame("a5", 0, 0);

        // Full frame plus one overflow byte
        tx_bytes.delete();
        for (int i = 0; i <= FRAME_BYTES; i++) tx_bytes.push_back(8'(i));
        run_frame("overflow", 0, 0);

        // Glitch between bits
        tx_bytes.delete();
        tx_bytes.push_back(8'h3C);
        run_frame("glitch", 0, 2);

        // Stuck-high line mid-frame
        clear_monitor();
        send_byte(8'h55, 0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        everloop_d = 1'b1;
        repeat (MAX_HI + 10) @(negedge clk);
        checkOutput("stuck err", err, 1);
        everloop_d = 1'b0;
        repeat (10) @(negedge clk);
        send_byte(8'h77, 0);
        repeat (GAP) @(negedge clk);
        checkOutput("stuck wr_count", wr_addr_q.size(), 1);
        if (wr_data_q.size() > 0) checkOutput("stuck first data", wr_data_q[0], 8'h55);
        checkOutput("stuck frame_done_count", fd_count, 0);
        checkOutput("stuck err held", err, 1);
        tx_bytes.delete();
        tx_bytes.push_back(8'h11);
        run_frame("after_stuck", 0, 0);

        // Partial byte before the gap
        tx_bytes.delete();
        run_frame("partial", 5, 0);

        // Asynchronous reset in the middle of a byte
        clear_monitor();
        send_byte(8'h5A, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        checkOutput("pre_reset address", address, 1);
        #2 rst = 1'b0;
        #1;
        checkOutput("async address", address, 0);
        checkOutput("async data_RGB", data_RGB, 0);
        checkOutput("async frame_len", frame_len, 0);
        checkOutput("async err", err, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        clear_monitor();
        send_byte(8'hC3, 0);
        repeat (50) @(negedge clk);
        checkOutput("no_gap wr_count", wr_addr_q.size(), 0);
        checkOutput("no_gap frame_done_count", fd_count, 0);
        repeat (GAP) @(negedge clk);

        // Randomized frames
        for (int f = 0; f < 8; f++) begin
            n = $urandom_range(4, 0);
            extra = ($urandom_range(3, 0) == 0) ? $urandom_range(7, 1) : 0;
            if (n == 0 && extra == 0) extra = 3;
            tx_bytes.delete();
            for (int i = 0; i < n; i++) tx_bytes.push_back(8'($urandom_range(255, 0)));
            run_frame($sformatf("rand%0d", f), extra, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
